v_dff_en: RTL and testbench
===========================

V_DFF_EN -- requirements
Module: v_dff_en

Interface
REQ-001 Parameter: n, default 1, data width in bits; must be the first parameter so that positional override (#8) sets width.
REQ-002 Parameter: RST_VAL, default all-zeros ('0), n-bit value loaded on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  load enable.
REQ-006 Port: in  input  n  data to capture.
REQ-007 Port: out  output  n  registered data.
REQ-008 Port order SHALL be clk, rst, en, in, out, so that existing positional instantiations bind correctly.

Function
REQ-009 At each rising clk edge with rst=1, out SHALL become RST_VAL, regardless of en and in.
REQ-010 At each rising clk edge with rst=0 and en=1, out SHALL become the value of in sampled at that edge.
REQ-011 At each rising clk edge with rst=0 and en=0, out SHALL hold its previous value.
REQ-012 Latency SHALL be exactly one clock from the sampled in to the visible out.
REQ-013 out SHALL be driven only by the register, with no combinational path from in, en or rst to out.
REQ-014 Simultaneous rst=1 and en=1: reset SHALL take priority.
REQ-015 Changes on in, en or rst between clock edges SHALL have no effect on out.
REQ-016 All n bits SHALL be loaded, held or reset together, with no partial-bit enables.
REQ-017 The block SHALL be legal for n=1 and for any n up to at least 64, with no truncation or extension.

Reset
REQ-018 Reset is synchronous and active-high (already decided); out SHALL equal RST_VAL from the first rising edge at which rst=1.
REQ-019 There SHALL be no asynchronous reset path, and out before the first reset edge is unspecified.
REQ-020 Reset asserted mid-operation SHALL discard the held value at the next edge, and the first edge with rst=0 and en=1 SHALL load in normally.

Structure
REQ-021 A single flat module SHALL be used, with no sub-modules and no shared package; n and RST_VAL are local parameters of the module.
REQ-022 The block SHALL be one clocked process using non-blocking assignment, with the rst test first, then en, then hold.
REQ-023 The block SHALL be reusable as the standard enabled register for datapath and pipeline registers (PC history, invalid flags and similar).

Verification
REQ-024 n=8: rst=1 with en=1, in=8'hA5, one edge -> out=8'h00.
REQ-025 n=8: rst=0, en=1, in=8'h3C, one edge -> out=8'h3C exactly one cycle after sampling, unchanged before the edge.
REQ-026 n=8: load 8'h3C, then en=0 while in toggles 8'hFF/8'h00 for 5 edges -> out stays 8'h3C.
REQ-027 n=1 (default): en=1, in toggles 1,0,1 over three edges -> out follows 1,0,1 with one-cycle delay, and a mid-cycle glitch on in has no effect.
REQ-028 n=8, RST_VAL=8'h01: after loading 8'h7E, assert rst for one edge with en=0 -> out=8'h01; next edge with rst=0, en=1, in=8'h10 -> out=8'h10.
REQ-029 Randomized check: 1000 cycles of random rst, en and in, compared against the reference model out_next = rst ? RST_VAL : (en ? in : out).

Source files
------------

// File: rtl/v_dff_en.sv
// Enabled n-bit register with synchronous active-high reset to RST_VAL.
// This is the standard enabled register for pipeline and datapath state, such as PC history and invalid flags.
module v_dff_en #(
   parameter int unsigned n       = 1,
   parameter logic [n-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [n-1:0] in,
   output logic [n-1:0] out
);

   logic [n-1:0] r_q;

   // Reset has priority over enable. With no enable, the register holds its whole value.
   always_ff @(posedge clk) begin
      if (rst)
         r_q <= RST_VAL;
      else if (en)
         r_q <= in;
   end

   assign out = r_q;

endmodule

// File: tb/tb_v_dff_en.sv
// Bench for v_dff_en: a reference model is compared against three instances on every cycle.
// Directed vectors with hand-computed expectations also pin the model.
module tb_v_dff_en;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [7:0] in8 = '0;
   logic [0:0] in1 = '0;
   logic [7:0] out8;
   logic [7:0] out8r;
   logic [0:0] out1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   v_dff_en #(.n(8)) u_d8 (
      .clk(clk), .rst(rst), .en(en), .in(in8), .out(out8)
   );
   v_dff_en #(.n(8), .RST_VAL(8'h01)) u_d8r (
      .clk(clk), .rst(rst), .en(en), .in(in8), .out(out8r)
   );
   v_dff_en u_d1 (
      .clk(clk), .rst(rst), .en(en), .in(in1), .out(out1)
   );

   // Reference model: out_next = rst ? RST_VAL : (en ? in : out)
   logic [7:0] m8, m8r;
   logic [0:0] m1;
   bit         valid = 1'b0;

   function automatic logic [7:0] ref_next(input logic r, input logic e,
                                           input logic [7:0] d, input logic [7:0] cur,
                                           input logic [7:0] rv);
      return r ? rv : (e ? d : cur);
   endfunction

   always @(posedge clk) begin
      m8  = ref_next(rst, en, in8, m8, 8'h00);
      m8r = ref_next(rst, en, in8, m8r, 8'h01);
      m1  = ref_next(rst, en, {7'd0, in1}, {7'd0, m1}, 8'h00) == 8'd1;
      if (rst) valid = 1'b1;
   end

   always @(negedge clk) begin
      if (valid) begin
         checks++;
         if (out8 !== m8 || out8r !== m8r || out1 !== m1) begin
            errors++;
            $display("FAIL model t=%0t out8=%h/%h out8r=%h/%h out1=%b/%b (actual/required)",
                     $time, out8, m8, out8r, m8r, out1, m1);
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic [7:0] d8, input logic d1);
      rst = r; en = e; in8 = d8; in1 = d1;
      @(negedge clk);
   endtask

   initial begin
      // Reset takes priority over enable.
      cyc(1'b1, 1'b1, 8'hA5, 1'b1);
      chk("rst_pri_d8", out8, 8'h00);
      chk("rst_pri_d8r", out8r, 8'h01);
      chk("rst_pri_d1", {7'd0, out1}, 8'h00);

      // Load with one-cycle latency. The output is unchanged before the edge.
      rst = 1'b0; en = 1'b1; in8 = 8'h3C; in1 = 1'b1;
      #2 chk("pre_edge_d8", out8, 8'h00);
      @(negedge clk);
      chk("load_3c", out8, 8'h3C);

      // Hold while the input toggles.
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, (i % 2 == 0) ? 8'hFF : 8'h00, i[0]);
         chk("hold_3c", out8, 8'h3C);
      end

      // Width-1 instance follows 1,0,1.
      cyc(1'b0, 1'b1, 8'h11, 1'b1); chk("d1_seq1", {7'd0, out1}, 8'h01);
      cyc(1'b0, 1'b1, 8'h22, 1'b0); chk("d1_seq0", {7'd0, out1}, 8'h00);
      cyc(1'b0, 1'b1, 8'h33, 1'b1); chk("d1_seq1b", {7'd0, out1}, 8'h01);

      // A mid-cycle glitch on in is not captured.
      rst = 1'b0; en = 1'b1; in1 = 1'b0;
      #2 in1 = 1'b1;
      #1 in1 = 1'b0;
      chk("glitch_pre", {7'd0, out1}, 8'h01);
      @(negedge clk);
      chk("glitch_post", {7'd0, out1}, 8'h00);

      // Non-zero RST_VAL: a mid-operation reset discards the held value, then the register loads normally.
      cyc(1'b0, 1'b1, 8'h7E, 1'b0); chk("d8r_load_7e", out8r, 8'h7E);
      cyc(1'b1, 1'b0, 8'hC3, 1'b1); chk("d8r_rst", out8r, 8'h01);
      chk("d8_rst", out8, 8'h00);
      cyc(1'b0, 1'b1, 8'h10, 1'b0); chk("d8r_after_rst", out8r, 8'h10);

      // Random traffic; the model process checks every cycle.
      for (int i = 0; i < 1000; i++)
         cyc(($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
             8'($urandom), $urandom_range(0, 1) == 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
